// File: rtl/axis_pkg.sv
// Shared constants and arbiter state encoding for the AXI-Stream merge blocks.
package axis_pkg;

  localparam int unsigned AXIS_NPORT = 4;
  localparam int unsigned AXIS_ID_W  = 2;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_LOCK = 1'b1
  } arb_state_e;

endpackage

// File: rtl/axis_rr_merge4_if.sv
// Signal bundle for the 4:1 AXI-Stream merger: four upstream lanes in, one tagged stream out.
interface axis_rr_merge4_if
  import axis_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) ();

  logic [DATA_W*AXIS_NPORT-1:0] s_axis_tdata;
  logic [AXIS_NPORT-1:0]        s_axis_tlast;
  logic [AXIS_NPORT-1:0]        s_axis_tvalid;
  logic [AXIS_NPORT-1:0]        s_axis_tready;
  logic [AXIS_NPORT-1:0]        s_en;
  logic [DATA_W-1:0]            m_axis_tdata;
  logic [AXIS_ID_W-1:0]         m_axis_tid;
  logic                         m_axis_tlast;
  logic                         m_axis_tvalid;
  logic                         m_axis_tready;

  // master: the merger itself, which drives the merged stream
  modport master (
    input  s_axis_tdata, s_axis_tlast, s_axis_tvalid, s_en, m_axis_tready,
    output s_axis_tready, m_axis_tdata, m_axis_tid, m_axis_tlast, m_axis_tvalid
  );

  // slave: the surrounding sources and sink
  modport slave (
    output s_axis_tdata, s_axis_tlast, s_axis_tvalid, s_en, m_axis_tready,
    input  s_axis_tready, m_axis_tdata, m_axis_tid, m_axis_tlast, m_axis_tvalid
  );

endinterface

// File: rtl/rr_pick4.sv
// Combinational 4-way round-robin pick: first requester searching upward from last_grant+1.
module rr_pick4 (
  input  logic [3:0] req,
  input  logic [1:0] last_grant,
  output logic       any,
  output logic [1:0] winner
);

  always_comb begin
    any    = |req;
    winner = last_grant;
    // Walk from farthest to nearest so the nearest requester wins.
    for (int k = 4; k >= 1; k--) begin
      if (req[last_grant + 2'(k)]) begin
        winner = last_grant + 2'(k);
      end
    end
  end

endmodule

// File: rtl/axis_rr_merge4.sv
// Packet-aware round-robin merge of four AXI-Stream lanes into one registered, tid-tagged stream.
module axis_rr_merge4
  import axis_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input logic              clk,
  input logic              rst,
  axis_rr_merge4_if.master bus
);

  arb_state_e state_q, state_d;
  logic [AXIS_ID_W-1:0]  last_grant_q, last_grant_d;
  logic [AXIS_ID_W-1:0]  owner_q, owner_d;
  logic [AXIS_ID_W-1:0]  sel, winner;
  logic [AXIS_NPORT-1:0] req, ready;
  logic                  any, out_free, accept, sel_last;
  logic [DATA_W-1:0]     sel_data;

  logic [DATA_W-1:0]    tdata_q;
  logic [AXIS_ID_W-1:0] tid_q;
  logic                 tlast_q, tvalid_q;

  assign out_free = ~tvalid_q | bus.m_axis_tready;
  assign req      = bus.s_axis_tvalid & bus.s_en;

  rr_pick4 u_pick (
    .req       (req),
    .last_grant(last_grant_q),
    .any       (any),
    .winner    (winner)
  );

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    ready        = '0;
    sel          = owner_q;

    unique case (state_q)
      ARB_IDLE: begin
        if (any) begin
          sel          = winner;
          ready[winner] = out_free;
        end
      end
      ARB_LOCK: ready[owner_q] = out_free;
    endcase

    if (rst) begin
      ready = '0;
    end

    accept   = |(bus.s_axis_tvalid & ready);
    sel_last = bus.s_axis_tlast[sel];

    unique case (state_q)
      ARB_IDLE: begin
        if (accept) begin
          last_grant_d = sel;
          if (!sel_last) begin
            owner_d = sel;
            state_d = ARB_LOCK;
          end
        end
      end
      ARB_LOCK: begin
        if (accept && sel_last) begin
          state_d = ARB_IDLE;
        end
      end
    endcase
  end

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < AXIS_NPORT; i++) begin
      if (sel == AXIS_ID_W'(i)) begin
        sel_data = bus.s_axis_tdata[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ARB_IDLE;
      last_grant_q <= AXIS_ID_W'(AXIS_NPORT - 1);
      owner_q      <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
    end
  end

  // Output register only moves when the downstream slot is empty or being drained.
  always_ff @(posedge clk) begin
    if (rst) begin
      tvalid_q <= 1'b0;
      tdata_q  <= '0;
      tid_q    <= '0;
      tlast_q  <= 1'b0;
    end else if (out_free) begin
      tvalid_q <= accept;
      if (accept) begin
        tdata_q <= sel_data;
        tid_q   <= sel;
        tlast_q <= sel_last;
      end
    end
  end

  assign bus.s_axis_tready = ready;
  assign bus.m_axis_tdata  = tdata_q;
  assign bus.m_axis_tid    = tid_q;
  assign bus.m_axis_tlast  = tlast_q;
  assign bus.m_axis_tvalid = tvalid_q;

endmodule

// File: tb/tb_axis_rr_merge4.sv
// Directed bench for axis_rr_merge4: per-lane source queues, output beat log, constant expectations.
module tb_axis_rr_merge4;

  localparam int unsigned DW = 32;

  typedef struct packed {
    logic          last;
    logic [DW-1:0] data;
  } beat_t;

  typedef struct packed {
    logic [1:0]    tid;
    logic          last;
    logic [DW-1:0] data;
  } obeat_t;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  axis_rr_merge4_if #(.DATA_W(DW)) bus ();

  axis_rr_merge4 #(.DATA_W(DW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  beat_t      src_q[4][$];
  obeat_t     out_q[$];
  logic [3:0] hold;
  int         n_checks = 0;
  int         n_errors = 0;

  logic [3:0]    sn_sready;
  logic          sn_mvalid, sn_tlast;
  logic [1:0]    sn_tid;
  logic [DW-1:0] sn_tdata;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < 4; i++) begin
      if (src_q[i].size() > 0 && !hold[i]) begin
        bus.s_axis_tvalid[i]            = 1'b1;
        bus.s_axis_tlast[i]             = src_q[i][0].last;
        bus.s_axis_tdata[i*DW +: DW]    = src_q[i][0].data;
      end else begin
        bus.s_axis_tvalid[i]            = 1'b0;
        bus.s_axis_tlast[i]             = 1'b0;
        bus.s_axis_tdata[i*DW +: DW]    = '0;
      end
    end
  endtask

  // Sample one cycle at the falling edge, then retire accepted beats after the rising edge.
  task automatic step();
    logic [3:0] acc;
    @(negedge clk);
    sn_sready = bus.s_axis_tready;
    sn_mvalid = bus.m_axis_tvalid;
    sn_tid    = bus.m_axis_tid;
    sn_tlast  = bus.m_axis_tlast;
    sn_tdata  = bus.m_axis_tdata;
    if (!rst && bus.m_axis_tvalid && bus.m_axis_tready) begin
      out_q.push_back({bus.m_axis_tid, bus.m_axis_tlast, bus.m_axis_tdata});
    end
    acc = bus.s_axis_tvalid & bus.s_axis_tready;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      if (acc[i]) src_q[i].delete(0);
    end
    drive();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic push(input int lane, input logic last, input logic [DW-1:0] data);
    beat_t b;
    b.last = last;
    b.data = data;
    src_q[lane].push_back(b);
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) src_q[i].delete();
    hold              = '0;
    bus.s_en          = 4'hF;
    bus.m_axis_tready = 1'b1;
    drive();
    step();
    step();
    rst = 1'b0;
    out_q.delete();
  endtask

  task automatic check_beat(input string tag, input int idx, input logic [1:0] tid,
                            input logic last, input logic [DW-1:0] data);
    obeat_t got;
    got = (idx < out_q.size()) ? out_q[idx] : '1;
    check(tag, got, {tid, last, data});
  endtask

  initial begin
    int sr1;

    // Reset state, with a lane requesting throughout.
    rst               = 1'b1;
    hold              = '0;
    bus.s_en          = 4'hF;
    bus.m_axis_tready = 1'b1;
    push(2, 1'b1, 32'h55);
    drive();
    step();
    step();
    check("rst_sready", sn_sready, 4'b0000);
    check("rst_mvalid", sn_mvalid, 1'b0);
    check("rst_payload", {sn_tid, sn_tlast, sn_tdata}, '0);

    // Single source: lane 2, three beats.
    reset_dut();
    push(2, 1'b0, 32'hA);
    push(2, 1'b0, 32'hB);
    push(2, 1'b1, 32'hC);
    drive();
    step();
    check("t1_grant", sn_sready, 4'b0100);
    check("t1_lat", sn_mvalid, 1'b0);
    step();
    check("t1_beat_a", {sn_mvalid, sn_tid, sn_tlast, sn_tdata}, {1'b1, 2'd2, 1'b0, 32'hA});
    step();
    check("t1_beat_b", {sn_mvalid, sn_tid, sn_tlast, sn_tdata}, {1'b1, 2'd2, 1'b0, 32'hB});
    step();
    check("t1_beat_c", {sn_mvalid, sn_tid, sn_tlast, sn_tdata}, {1'b1, 2'd2, 1'b1, 32'hC});
    check("t1_idle_ready", sn_sready, 4'b0000);

    // Round robin over four continuously requesting lanes.
    reset_dut();
    for (int k = 0; k < 2; k++) begin
      for (int l = 0; l < 4; l++) push(l, 1'b1, 32'h100 + l * 16 + k);
    end
    drive();
    step();
    for (int j = 0; j < 8; j++) begin
      step();
      check("t2_tid", {sn_mvalid, sn_tid}, {1'b1, 2'(j % 4)});
    end
    for (int j = 0; j < 8; j++) begin
      check_beat("t2_data", j, 2'(j % 4), 1'b1, 32'h100 + (j % 4) * 16 + j / 4);
    end

    // No interleave: lane 0 packet with a two-cycle bubble, lane 1 waiting.
    reset_dut();
    push(0, 1'b0, 32'hD0);
    push(0, 1'b0, 32'hD1);
    push(0, 1'b0, 32'hD2);
    push(0, 1'b1, 32'hD3);
    push(1, 1'b1, 32'hE1);
    drive();
    sr1 = 0;
    step();
    check("t3_first", sn_sready, 4'b0001);
    sr1 |= int'(sn_sready[1]);
    step();
    sr1 |= int'(sn_sready[1]);
    hold[0] = 1'b1;
    drive();
    step();
    sr1 |= int'(sn_sready[1]);
    step();
    sr1 |= int'(sn_sready[1]);
    hold[0] = 1'b0;
    drive();
    step();
    sr1 |= int'(sn_sready[1]);
    step();
    sr1 |= int'(sn_sready[1]);
    check("t3_l1_blocked", sr1, 0);
    step();
    check("t3_l1_grant", sn_sready, 4'b0010);
    run(2);
    check("t3_count", out_q.size(), 5);
    check_beat("t3_b0", 0, 2'd0, 1'b0, 32'hD0);
    check_beat("t3_b1", 1, 2'd0, 1'b0, 32'hD1);
    check_beat("t3_b2", 2, 2'd0, 1'b0, 32'hD2);
    check_beat("t3_b3", 3, 2'd0, 1'b1, 32'hD3);
    check_beat("t3_b4", 4, 2'd1, 1'b1, 32'hE1);

    // Backpressure for five cycles mid-packet.
    reset_dut();
    push(1, 1'b0, 32'h40);
    push(1, 1'b0, 32'h41);
    push(1, 1'b0, 32'h42);
    push(1, 1'b1, 32'h43);
    push(2, 1'b1, 32'hF0);
    drive();
    run(3);
    bus.m_axis_tready = 1'b0;
    for (int j = 0; j < 5; j++) begin
      step();
      check("t4_stall", {sn_mvalid, sn_tid, sn_tlast, sn_tdata, sn_sready},
            {1'b1, 2'd1, 1'b0, 32'h42, 4'b0000});
    end
    bus.m_axis_tready = 1'b1;
    run(4);
    check("t4_count", out_q.size(), 5);
    check_beat("t4_b0", 0, 2'd1, 1'b0, 32'h40);
    check_beat("t4_b1", 1, 2'd1, 1'b0, 32'h41);
    check_beat("t4_b2", 2, 2'd1, 1'b0, 32'h42);
    check_beat("t4_b3", 3, 2'd1, 1'b1, 32'h43);
    check_beat("t4_b4", 4, 2'd2, 1'b1, 32'hF0);

    // Enable mask; lane 1 disabled mid-packet still finishes.
    reset_dut();
    bus.s_en = 4'b1010;
    push(0, 1'b1, 32'h500);
    push(2, 1'b1, 32'h520);
    push(1, 1'b0, 32'h510);
    push(1, 1'b0, 32'h511);
    push(1, 1'b1, 32'h512);
    push(3, 1'b1, 32'h530);
    drive();
    step();
    check("t5_grant1", sn_sready, 4'b0010);
    bus.s_en = 4'b1000;
    run(7);
    check("t5_count", out_q.size(), 4);
    check_beat("t5_b0", 0, 2'd1, 1'b0, 32'h510);
    check_beat("t5_b1", 1, 2'd1, 1'b0, 32'h511);
    check_beat("t5_b2", 2, 2'd1, 1'b1, 32'h512);
    check_beat("t5_b3", 3, 2'd3, 1'b1, 32'h530);
    check("t5_lane0_left", src_q[0].size(), 1);
    check("t5_lane2_left", src_q[2].size(), 1);

    // Reset during lane 3's packet; lane 0 wins afterwards.
    reset_dut();
    push(3, 1'b0, 32'h60);
    push(3, 1'b0, 32'h61);
    push(3, 1'b0, 32'h62);
    push(3, 1'b1, 32'h63);
    drive();
    run(2);
    rst = 1'b1;
    push(0, 1'b1, 32'h70);
    drive();
    step();
    check("t6_rst_sready", sn_sready, 4'b0000);
    rst = 1'b0;
    out_q.delete();
    step();
    check("t6_post_mvalid", sn_mvalid, 1'b0);
    check("t6_post_grant", sn_sready, 4'b0001);
    run(4);
    check("t6_count", out_q.size(), 3);
    check_beat("t6_b0", 0, 2'd0, 1'b1, 32'h70);
    check_beat("t6_b1", 1, 2'd3, 1'b0, 32'h62);
    check_beat("t6_b2", 2, 2'd3, 1'b1, 32'h63);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
